pk_host: RTL and testbench

Host-side end of the control-panel serial link: it encodes front-panel state (data keys, function switches, rotary position) into the one-byte command protocol consumed by the panel unit, and decodes that unit's 4-byte status reply into LED-level outputs. It sits between physical panel inputs or a test host and a byte-level UART pair (`tx_byte/send/tx_busy`, `rx_byte/rx_busy`). It owns change detection, arbitration, transmit handshake, periodic polling and reply reassembly with timeout.

---
 rtl/pk_host_pkg.sv | 30 +++
 rtl/pk_status_rx.sv | 84 ++++++++
 rtl/pk_host.sv | 131 +++++++++++++
 tb/tb_pk_host.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pk_host_pkg.sv
// Shared protocol definitions for the control-panel link: FN indices, command
// prefixes, poll byte and status reply layout. The panel unit uses the same values.
package pk_host_pkg;

  typedef enum logic [2:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_GAP, ST_RX} st_e;

  localparam logic [3:0] FN_START = 4'd0;
  localparam logic [3:0] FN_MODE  = 4'd1;
  localparam logic [3:0] FN_CLOCK = 4'd2;
  localparam logic [3:0] FN_STOPN = 4'd3;
  localparam logic [3:0] FN_CLEAR = 4'd11;

  localparam logic [2:0] PFX_FN   = 3'b001;
  localparam logic [1:0] PFX_K0   = 2'b01;
  localparam logic [2:0] PFX_K1   = 3'b100;
  localparam logic [2:0] PFX_K2   = 3'b101;
  localparam logic [2:0] PFX_POLL = 3'b110;
  localparam logic [3:0] PFX_ROT  = 4'b1110;
  localparam logic [7:0] CMD_POLL = {PFX_POLL, 5'd0};

  // Reply byte 3: [7:4] rotary echo, [3] wait, [0] alarm; bits 2:1 reserved.
  localparam int R3_ROT_LSB = 4;
  localparam int R3_WAIT    = 3;
  localparam int R3_ALARM   = 0;

  function automatic logic [7:0] fn_byte(input logic [3:0] fn, input logic val);
    return {PFX_FN, fn, val};
  endfunction

endpackage

// File: rtl/pk_status_rx.sv
// Status reply collector: counts four bytes on rx_busy falling edges after arm,
// then updates all LED-level outputs at once, or gives up after RX_TIMEOUT clocks.
module pk_status_rx import pk_host_pkg::*; #(
  parameter int unsigned RX_TIMEOUT = 5_000_000
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        arm,
  input  logic [7:0]  rx_byte,
  input  logic        rx_busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] w,
  output logic [7:0]  led,
  output logic [3:0]  rot_echo,
  output logic        wait_led,
  output logic        alarm_led
);

  logic        busy_q, active_q, active_d, done_q, done_d, tmo_hit_q, tmo_hit_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] tmo_q, tmo_d;
  logic [7:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, led_q, led_d;
  logic [15:0] w_q, w_d;
  logic [3:0]  rot_q, rot_d;
  logic        wait_q, wait_d, alarm_q, alarm_d, fall;

  assign fall = busy_q & ~rx_busy;

  always_comb begin
    active_d = active_q; cnt_d = cnt_q; tmo_d = tmo_q;
    b0_d = b0_q; b1_d = b1_q; b2_d = b2_q;
    w_d = w_q; led_d = led_q; rot_d = rot_q; wait_d = wait_q; alarm_d = alarm_q;
    done_d = 1'b0; tmo_hit_d = 1'b0;
    if (arm) begin
      active_d = 1'b1; cnt_d = 2'd0; tmo_d = '0;
    end else if (active_q) begin
      tmo_d = tmo_q + 32'd1;
      if (fall) begin
        cnt_d = cnt_q + 2'd1;
        case (cnt_q)
          2'd0: b0_d = rx_byte;
          2'd1: b1_d = rx_byte;
          2'd2: b2_d = rx_byte;
          default: begin
            w_d      = {b0_q, b1_q};
            led_d    = b2_q;
            rot_d    = rx_byte[R3_ROT_LSB +: 4];
            wait_d   = rx_byte[R3_WAIT];
            alarm_d  = rx_byte[R3_ALARM];
            done_d   = 1'b1;
            active_d = 1'b0;
          end
        endcase
      end else if (tmo_q + 32'd1 >= RX_TIMEOUT) begin
        tmo_hit_d = 1'b1;
        active_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      busy_q <= 1'b0; active_q <= 1'b0; cnt_q <= 2'd0; tmo_q <= '0;
      b0_q <= '0; b1_q <= '0; b2_q <= '0;
      w_q <= '0; led_q <= '0; rot_q <= '0; wait_q <= 1'b0; alarm_q <= 1'b0;
      done_q <= 1'b0; tmo_hit_q <= 1'b0;
    end else begin
      busy_q <= rx_busy; active_q <= active_d; cnt_q <= cnt_d; tmo_q <= tmo_d;
      b0_q <= b0_d; b1_q <= b1_d; b2_q <= b2_d;
      w_q <= w_d; led_q <= led_d; rot_q <= rot_d; wait_q <= wait_d; alarm_q <= alarm_d;
      done_q <= done_d; tmo_hit_q <= tmo_hit_d;
    end
  end

  assign done = done_q;
  assign timeout = tmo_hit_q;
  assign w = w_q;
  assign led = led_q;
  assign rot_echo = rot_q;
  assign wait_led = wait_q;
  assign alarm_led = alarm_q;

endmodule

// File: rtl/pk_host.sv
// Host end of the panel link: change detection against shadows, fixed-priority
// command selection, UART transmit handshake, auto-poll and reply reassembly.
module pk_host import pk_host_pkg::*; #(
  parameter int unsigned POLL_CYCLES = 2_500_000,
  parameter int unsigned GAP_CYCLES  = 64,
  parameter int unsigned RX_TIMEOUT  = 5_000_000
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic [15:0] keys,
  input  logic        sw_start,
  input  logic        sw_mode,
  input  logic        sw_clock,
  input  logic [8:0]  press,
  input  logic [3:0]  rotary,
  input  logic        poll_req,
  output logic [7:0]  tx_byte,
  output logic        send,
  input  logic        tx_busy,
  input  logic [7:0]  rx_byte,
  input  logic        rx_busy,
  output logic [15:0] w,
  output logic [7:0]  led,
  output logic [3:0]  rot_echo,
  output logic        wait_led,
  output logic        alarm_led,
  output logic        status_valid,
  output logic        status_timeout
);

  st_e         state_q, state_d;
  logic [15:0] keys_q, sh_keys_q, sh_keys_d;
  logic [2:0]  sw_q, sh_sw_q, sh_sw_d;
  logic [3:0]  rot_q, sh_rot_q, sh_rot_d;
  logic [8:0]  press_pend_q, press_pend_d, press_clr;
  logic        poll_pend_q, poll_pend_d, poll_clr, auto_hit;
  logic [31:0] poll_cnt_q, poll_cnt_d, gap_cnt_q, gap_cnt_d;
  logic        is_poll_q, is_poll_d, found, arm;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [2:0]  idx;

  always_comb begin
    state_d = state_q; tx_byte_d = tx_byte_q; is_poll_d = is_poll_q;
    sh_keys_d = sh_keys_q; sh_sw_d = sh_sw_q; sh_rot_d = sh_rot_q;
    gap_cnt_d = gap_cnt_q; poll_cnt_d = poll_cnt_q;
    press_clr = '0; poll_clr = 1'b0; found = 1'b0; idx = 3'd0;
    send = 1'b0; arm = 1'b0;
    auto_hit = (POLL_CYCLES != 0) && (poll_cnt_q == '0);
    if (POLL_CYCLES != 0 && poll_cnt_q != '0) poll_cnt_d = poll_cnt_q - 32'd1;
    for (int i = 7; i >= 0; i--) if (press_pend_q[i]) idx = 3'(i);
    case (state_q)
      ST_IDLE: begin
        found = 1'b1;
        is_poll_d = 1'b0;
        if (press_pend_q[8]) begin
          tx_byte_d = fn_byte(FN_CLEAR, 1'b1); press_clr[8] = 1'b1;
        end else if (sw_q[0] != sh_sw_q[0]) begin
          tx_byte_d = fn_byte(FN_START, sw_q[0]); sh_sw_d[0] = sw_q[0];
        end else if (sw_q[1] != sh_sw_q[1]) begin
          tx_byte_d = fn_byte(FN_MODE, sw_q[1]); sh_sw_d[1] = sw_q[1];
        end else if (sw_q[2] != sh_sw_q[2]) begin
          tx_byte_d = fn_byte(FN_CLOCK, sw_q[2]); sh_sw_d[2] = sw_q[2];
        end else if (|press_pend_q[7:0]) begin
          tx_byte_d = fn_byte(FN_STOPN + {1'b0, idx}, 1'b1); press_clr[idx] = 1'b1;
        end else if (rot_q != sh_rot_q) begin
          tx_byte_d = {PFX_ROT, rot_q}; sh_rot_d = rot_q;
        end else if (keys_q[5:0] != sh_keys_q[5:0]) begin
          tx_byte_d = {PFX_K0, keys_q[5:0]}; sh_keys_d[5:0] = keys_q[5:0];
        end else if (keys_q[10:6] != sh_keys_q[10:6]) begin
          tx_byte_d = {PFX_K1, keys_q[10:6]}; sh_keys_d[10:6] = keys_q[10:6];
        end else if (keys_q[15:11] != sh_keys_q[15:11]) begin
          tx_byte_d = {PFX_K2, keys_q[15:11]}; sh_keys_d[15:11] = keys_q[15:11];
        end else if (poll_pend_q) begin
          tx_byte_d = CMD_POLL; is_poll_d = 1'b1; poll_clr = 1'b1;
          poll_cnt_d = POLL_CYCLES - 32'd1;
        end else begin
          found = 1'b0;
        end
        if (found) state_d = ST_SEND;
      end
      ST_SEND: begin
        send = 1'b1;
        if (tx_busy) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        gap_cnt_d = '0;
        if (!tx_busy) begin
          state_d = is_poll_q ? ST_RX : ST_GAP;
          arm = is_poll_q;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q + 32'd1 >= GAP_CYCLES) state_d = ST_IDLE;
        else gap_cnt_d = gap_cnt_q + 32'd1;
      end
      ST_RX: begin
        gap_cnt_d = '0;
        if (status_valid || status_timeout) state_d = ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
    // A fresh request in the load cycle survives the clear; the counter reload does not.
    press_pend_d = (press_pend_q & ~press_clr) | press;
    poll_pend_d  = (poll_pend_q & ~poll_clr) | poll_req | (auto_hit & ~poll_clr);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_IDLE; tx_byte_q <= '0; is_poll_q <= 1'b0;
      keys_q <= '0; sw_q <= '0; rot_q <= 4'd1;
      sh_keys_q <= '0; sh_sw_q <= '0; sh_rot_q <= 4'd1;
      press_pend_q <= '0; poll_pend_q <= 1'b0;
      poll_cnt_q <= POLL_CYCLES - 32'd1; gap_cnt_q <= '0;
    end else begin
      state_q <= state_d; tx_byte_q <= tx_byte_d; is_poll_q <= is_poll_d;
      keys_q <= keys; sw_q <= {sw_clock, sw_mode, sw_start}; rot_q <= rotary;
      sh_keys_q <= sh_keys_d; sh_sw_q <= sh_sw_d; sh_rot_q <= sh_rot_d;
      press_pend_q <= press_pend_d; poll_pend_q <= poll_pend_d;
      poll_cnt_q <= poll_cnt_d; gap_cnt_q <= gap_cnt_d;
    end
  end

  assign tx_byte = tx_byte_q;

  pk_status_rx #(.RX_TIMEOUT(RX_TIMEOUT)) u_rx (
    .clk(clk), .rst_(rst_), .arm(arm), .rx_byte(rx_byte), .rx_busy(rx_busy),
    .done(status_valid), .timeout(status_timeout), .w(w), .led(led),
    .rot_echo(rot_echo), .wait_led(wait_led), .alarm_led(alarm_led)
  );

endmodule

// File: tb/tb_pk_host.sv
// Directed bench for pk_host with a small UART transmitter model and hand-built replies.
module tb_pk_host;
  localparam int GAP = 8;
  localparam int TMO = 200;

  logic clk = 0, rst_ = 0;
  logic [15:0] keys = 16'h8001;
  logic sw_start = 0, sw_mode = 0, sw_clock = 0, poll_req = 0;
  logic [8:0] press = '0;
  logic [3:0] rotary = 4'd0;
  logic [7:0] tx_byte, rx_byte = '0;
  logic send, tx_busy, rx_busy = 0;
  logic [15:0] w;
  logic [7:0] led;
  logic [3:0] rot_echo;
  logic wait_led, alarm_led, status_valid, status_timeout;

  int checks = 0, errors = 0, cyc = 0, sv_cnt = 0, to_cnt = 0;
  logic uart_hold = 0;
  logic [7:0] txq[$];
  int tq[$];

  pk_host #(.POLL_CYCLES(0), .GAP_CYCLES(GAP), .RX_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_(rst_), .keys(keys), .sw_start(sw_start), .sw_mode(sw_mode),
    .sw_clock(sw_clock), .press(press), .rotary(rotary), .poll_req(poll_req),
    .tx_byte(tx_byte), .send(send), .tx_busy(tx_busy), .rx_byte(rx_byte),
    .rx_busy(rx_busy), .w(w), .led(led), .rot_echo(rot_echo), .wait_led(wait_led),
    .alarm_led(alarm_led), .status_valid(status_valid), .status_timeout(status_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    if (status_valid) sv_cnt++;
    if (status_timeout) to_cnt++;
  end

  initial begin
    tx_busy = 0;
    forever begin
      @(negedge clk);
      if (send && !tx_busy && !uart_hold) begin
        txq.push_back(tx_byte); tq.push_back(cyc);
        tx_busy = 1;
        repeat (8) @(negedge clk);
        tx_busy = 0;
      end
    end
  end

  task automatic wait_bytes(input int n);
    int b = 0;
    while (txq.size() < n && b < 3000) begin @(negedge clk); b++; end
    checks++;
    if (txq.size() < n) begin
      errors++; $display("FAIL wait_bytes: got %0d bytes, need %0d", txq.size(), n);
    end
  endtask

  task automatic check_seq(input string name, input logic [7:0] exp[]);
    logic [7:0] got;
    wait_bytes(exp.size());
    repeat (150) @(negedge clk);
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < txq.size()) ? txq[i] : 8'hxx;
      checks++;
      if (got !== exp[i]) begin
        errors++; $display("FAIL %s[%0d]: got %h want %h", name, i, got, exp[i]);
      end
    end
    checks++;
    if (txq.size() != exp.size()) begin
      errors++; $display("FAIL %s_count: got %0d want %0d", name, txq.size(), exp.size());
    end
  endtask

  task automatic rx_send(input logic [7:0] b);
    rx_byte = b; rx_busy = 1;
    repeat (3) @(negedge clk);
    rx_busy = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_poll();
    int b = 0;
    txq.delete(); tq.delete();
    poll_req = 1; @(negedge clk); poll_req = 0;
    wait_bytes(1);
    checks++;
    if (txq.size() < 1 || txq[0] !== 8'hC0) begin
      errors++; $display("FAIL poll_byte: got %h want c0", txq.size() ? txq[0] : 8'hxx);
    end
    while (tx_busy && b < 100) begin @(negedge clk); b++; end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_byte, send, w, led, rot_echo, wait_led, alarm_led, status_valid, status_timeout} !== '0) begin
      errors++; $display("FAIL reset_outputs: tx=%h send=%b w=%h led=%h rot=%h got nonzero, want 0",
                         tx_byte, send, w, led, rot_echo);
    end
    rst_ = 1;
  endtask

  task automatic test_first_bytes();
    check_seq("first", '{8'hE0, 8'h41, 8'hB0});
    for (int i = 1; i < 3 && i < tq.size(); i++) begin
      checks++;
      if (tq[i] - tq[i-1] < GAP) begin
        errors++; $display("FAIL first_gap[%0d]: got %0d want >= %0d", i, tq[i] - tq[i-1], GAP);
      end
    end
  endtask

  task automatic test_press_clear();
    txq.delete(); tq.delete();
    press = 9'h101; sw_start = 1;
    @(negedge clk); press = '0;
    check_seq("clear", '{8'h37, 8'h21, 8'h27});
  endtask

  task automatic test_merge();
    int b = 0;
    txq.delete(); tq.delete();
    rotary = 4'd5;
    while (!tx_busy && b < 100) begin @(negedge clk); b++; end
    repeat (3) begin press = 9'h002; @(negedge clk); press = '0; @(negedge clk); end
    check_seq("merge", '{8'hE5, 8'h29});
  endtask

  task automatic test_poll();
    int sv0 = sv_cnt;
    do_poll();
    rx_send(8'h12); rx_send(8'h34); rx_send(8'hA5); rx_send(8'h13);
    repeat (3) @(negedge clk);
    checks++;
    if (w !== 16'h1234) begin errors++; $display("FAIL poll_w: got %h want 1234", w); end
    checks++;
    if (led !== 8'hA5) begin errors++; $display("FAIL poll_led: got %h want a5", led); end
    checks++;
    if ({rot_echo, wait_led, alarm_led} !== 6'b0001_0_1) begin
      errors++; $display("FAIL poll_b3: rot=%h wait=%b alarm=%b want 1 0 1", rot_echo, wait_led, alarm_led);
    end
    checks++;
    if (sv_cnt - sv0 != 1) begin errors++; $display("FAIL poll_valid: got %0d pulses want 1", sv_cnt - sv0); end
  endtask

  task automatic test_timeout();
    int sv0 = sv_cnt, to0 = to_cnt, b = 0;
    do_poll();
    rx_send(8'hDE); rx_send(8'hAD);
    while (to_cnt == to0 && b < 2 * TMO) begin @(negedge clk); b++; end
    checks++;
    if (to_cnt - to0 != 1) begin errors++; $display("FAIL tmo_pulse: got %0d want 1", to_cnt - to0); end
    repeat (2 * GAP) @(negedge clk);
    rx_send(8'hFF);
    repeat (20) @(negedge clk);
    checks++;
    if ({w, led, rot_echo, wait_led, alarm_led} !== {16'h1234, 8'hA5, 4'h1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL tmo_hold: w=%h led=%h rot=%h want 1234 a5 1", w, led, rot_echo);
    end
    checks++;
    if (sv_cnt != sv0) begin errors++; $display("FAIL tmo_valid: got %0d pulses want 0", sv_cnt - sv0); end
    do_poll();
    rx_send(8'h56); rx_send(8'h78); rx_send(8'h0F); rx_send(8'hF8);
    repeat (3) @(negedge clk);
    checks++;
    if ({w, led, rot_echo, wait_led, alarm_led} !== {16'h5678, 8'h0F, 4'hF, 1'b1, 1'b0}) begin
      errors++; $display("FAIL repoll: w=%h led=%h rot=%h wait=%b alarm=%b want 5678 0f f 1 0",
                         w, led, rot_echo, wait_led, alarm_led);
    end
  endtask

  task automatic test_reset_mid_send();
    int b = 0;
    repeat (4 * GAP) @(negedge clk);
    txq.delete(); tq.delete();
    uart_hold = 1; rotary = 4'd9;
    while (!send && b < 100) begin @(negedge clk); b++; end
    checks++;
    if (send !== 1'b1) begin errors++; $display("FAIL rst_send_rise: got %b want 1", send); end
    #2 rst_ = 0;
    #1;
    checks++;
    if (send !== 1'b0 || tx_byte !== 8'h00) begin
      errors++; $display("FAIL rst_async: send=%b tx=%h want 0 00", send, tx_byte);
    end
    @(negedge clk); rst_ = 1; uart_hold = 0;
    check_seq("after_rst", '{8'h21, 8'hE9, 8'h41, 8'hB0});
  endtask

  initial begin
    test_reset();
    test_first_bytes();
    test_press_clear();
    test_merge();
    test_poll();
    test_timeout();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end
endmodule
